mem_arbiter_rr: RTL and testbench

//  N-requester arbiter for the shared physical-memory port below the L1 caches.

---
 rtl/mem_arbiter_rr.sv | 197 +++++++++++++++++++
 tb/tb_mem_arbiter_rr.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter_rr.sv
// ----------------------------------------------------------------------------
// mem_arbiter_rr
//
// Purpose:
//   Arbitrates NUM_REQ requesters (index 0 = data cache) onto the single
//   shared physical-memory port below the L1 caches. The arbiter is either
//   fixed priority (lowest index wins) or round-robin. The grant is
//   registered and held until the memory signals completion. The completion
//   strobe is then routed back to the owning requester only. The
//   address/data muxing lives outside this block and is steered by
//   grant_idx.
//
// Handshake (one rule for every client):
//   A requester raises req_read and/or req_write as a level and holds it
//   until it sees its own resp_out bit. The memory raises s_resp for exactly
//   the cycle in which the current access completes. In that same cycle
//   mem_read/mem_write drop, and after it one GAP cycle with no grant
//   follows. This gives the owner time to lower its level before the
//   arbiter looks at the request lines again. If the owner lowers its level
//   before s_resp arrives, the access is abandoned and no resp_out is
//   produced.
//
// Parameters:
//   NUM_REQ   number of requesters, 2..16
//   RR_MODE   1 = round-robin, 0 = fixed priority
//   IDXW      grant index width (derived from NUM_REQ, minimum 1)
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   rst_n      asynchronous active-low reset
//   req_read   per-requester read request level
//   req_write  per-requester write request level
//   s_resp     memory completion strobe for the current grant
//   grant      one-hot owner of the memory port (registered)
//   grant_idx  binary owner index; holds the last owner when idle
//   mem_read   owner's read request forwarded while busy, dropped on s_resp
//   mem_write  owner's write request forwarded while busy, dropped on s_resp
//   resp_out   s_resp routed to the owner
//   state_dbg  current FSM state (0 = IDLE, 1 = BUSY, 2 = GAP)
// ----------------------------------------------------------------------------
module mem_arbiter_rr #(
    parameter int NUM_REQ = 2,
    parameter int RR_MODE = 1,
    parameter int IDXW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req_read,
    input  logic [NUM_REQ-1:0] req_write,
    input  logic               s_resp,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDXW-1:0]    grant_idx,
    output logic               mem_read,
    output logic               mem_write,
    output logic [NUM_REQ-1:0] resp_out,
    output logic [1:0]         state_dbg
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [IDXW-1:0]      idx_q, idx_d;
    logic [IDXW-1:0]      ptr_q, ptr_d;

    logic [NUM_REQ-1:0]   active;
    logic [IDXW-1:0]      scan_start;
    logic                 win_found;
    logic [IDXW-1:0]      win_idx;
    logic                 busy;

    // Index addition modulo NUM_REQ. The wrap is done explicitly, so a
    // NUM_REQ that is not a power of two never yields an out-of-range index.
    function automatic logic [IDXW-1:0] wrap_add(input logic [IDXW-1:0] base,
                                                 input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= NUM_REQ) begin
            sum = sum - NUM_REQ;
        end
        return IDXW'(sum);
    endfunction

    assign active = req_read | req_write;

    // ------------------------------------------------------------------
    // Winner search: walk the requesters starting at scan_start and take
    // the first active one. Fixed priority always starts the walk at 0.
    // Round-robin starts at the slot after the last completed owner.
    // ------------------------------------------------------------------
    always_comb begin
        logic [IDXW-1:0] cand;
        scan_start = (RR_MODE != 0) ? ptr_q : '0;
        win_found  = 1'b0;
        win_idx    = '0;
        cand       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = wrap_add(scan_start, k);
            if (!win_found && active[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // ------------------------------------------------------------------
    // State register (with grant, owner index and round-robin pointer).
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            idx_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_IDLE: begin
                grant_d = '0;
                if (win_found) begin
                    state_d          = ST_BUSY;
                    grant_d[win_idx] = 1'b1;
                    idx_d            = win_idx;
                end
            end
            ST_BUSY: begin
                // Completion takes precedence over the owner dropping its
                // request in the same cycle. Other requesters never preempt.
                if (s_resp) begin
                    state_d = ST_GAP;
                    grant_d = '0;
                    if (RR_MODE != 0) begin
                        ptr_d = wrap_add(idx_q, 1);
                    end
                end else if (!active[idx_q]) begin
                    // Abandoned access: the fairness pointer is left alone.
                    state_d = ST_IDLE;
                    grant_d = '0;
                end
            end
            ST_GAP: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic. The access lines drop in the s_resp cycle. They are
    // also gated by rst_n so that they clear during reset without waiting
    // for a clock edge.
    // ------------------------------------------------------------------
    always_comb begin
        busy      = (state_q == ST_BUSY);
        mem_read  = rst_n & busy & req_read[idx_q]  & ~s_resp;
        mem_write = rst_n & busy & req_write[idx_q] & ~s_resp;
        resp_out  = grant_q & {NUM_REQ{s_resp & rst_n}};
        grant     = grant_q;
        grant_idx = idx_q;
        state_dbg = state_q;
    end

    // ------------------------------------------------------------------
    // Structural invariants of the grant register.
    // ------------------------------------------------------------------
    a_grant_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(grant_q));
    a_grant_iff_busy: assert property (@(posedge clk) disable iff (!rst_n)
        ((grant_q != '0) == (state_q == ST_BUSY)));
    a_grant_matches_idx: assert property (@(posedge clk) disable iff (!rst_n)
        (state_q == ST_BUSY) |-> grant_q[idx_q]);
    a_idx_in_range: assert property (@(posedge clk) disable iff (!rst_n)
        (int'(idx_q) < NUM_REQ) && (int'(ptr_q) < NUM_REQ));

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// ----------------------------------------------------------------------------
// tb_mem_arbiter_rr
//
// Three arbiters share one stimulus bus (each takes the low slice it needs):
//   u4: NUM_REQ=4 round-robin, u3: NUM_REQ=3 round-robin, u2: NUM_REQ=2 fixed.
// A per-instance reference model (owner / gap / pointer as integers) is
// compared against every instance each cycle. A vector table and a few
// hand-written sequences pin down specific grant orders and corner cases.
// ----------------------------------------------------------------------------
module tb_mem_arbiter_rr;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [15:0] req_rd;
    logic [15:0] req_wr;
    logic        s_resp;

    logic [3:0] g4, ro4;  logic [1:0] i4;  logic [1:0] st4;  logic mr4, mw4;
    logic [2:0] g3, ro3;  logic [1:0] i3;  logic [1:0] st3;  logic mr3, mw3;
    logic [1:0] g2, ro2;  logic [0:0] i2;  logic [1:0] st2;  logic mr2, mw2;

    mem_arbiter_rr #(.NUM_REQ(4), .RR_MODE(1)) u4 (
        .clk(clk), .rst_n(rst_n), .req_read(req_rd[3:0]), .req_write(req_wr[3:0]),
        .s_resp(s_resp), .grant(g4), .grant_idx(i4), .mem_read(mr4),
        .mem_write(mw4), .resp_out(ro4), .state_dbg(st4));

    mem_arbiter_rr #(.NUM_REQ(3), .RR_MODE(1)) u3 (
        .clk(clk), .rst_n(rst_n), .req_read(req_rd[2:0]), .req_write(req_wr[2:0]),
        .s_resp(s_resp), .grant(g3), .grant_idx(i3), .mem_read(mr3),
        .mem_write(mw3), .resp_out(ro3), .state_dbg(st3));

    mem_arbiter_rr #(.NUM_REQ(2), .RR_MODE(0)) u2 (
        .clk(clk), .rst_n(rst_n), .req_read(req_rd[1:0]), .req_write(req_wr[1:0]),
        .s_resp(s_resp), .grant(g2), .grant_idx(i2), .mem_read(mr2),
        .mem_write(mw2), .resp_out(ro2), .state_dbg(st2));

    // ---------------- scoreboard counters ----------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic compare(input string name, input logic [63:0] act,
                           input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    localparam int NR  [3] = '{4, 3, 2};
    localparam int RRM [3] = '{1, 1, 0};

    int m_owner [3];   // -1 = nobody owns the port
    int m_last  [3];   // last granted index
    int m_ptr   [3];   // round-robin start position
    bit m_gap   [3];   // in the post-completion dead cycle

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_owner[k] = -1;
            m_last[k]  = 0;
            m_ptr[k]   = 0;
            m_gap[k]   = 1'b0;
        end
    endtask

    task automatic model_step();
        int n, o, start, c;
        for (int k = 0; k < 3; k++) begin
            n = NR[k];
            o = m_owner[k];
            if (m_gap[k]) begin
                m_gap[k] = 1'b0;
            end else if (o < 0) begin
                start = (RRM[k] != 0) ? m_ptr[k] : 0;
                for (int j = 0; j < n; j++) begin
                    c = (start + j) % n;
                    if (m_owner[k] < 0 && (req_rd[c] || req_wr[c])) begin
                        m_owner[k] = c;
                        m_last[k]  = c;
                    end
                end
            end else if (s_resp) begin
                if (RRM[k] != 0) m_ptr[k] = (o + 1) % n;
                m_owner[k] = -1;
                m_gap[k]   = 1'b1;
            end else if (!(req_rd[o] || req_wr[o])) begin
                m_owner[k] = -1;
            end
        end
    endtask

    // Packed view {state, idx, grant, resp_out, mem_read, mem_write}.
    function automatic logic [39:0] model_obs(input int k);
        logic [15:0] g;
        logic [1:0]  st;
        logic        mr, mw;
        int          o;
        o  = m_owner[k];
        g  = '0;
        mr = 1'b0;
        mw = 1'b0;
        st = m_gap[k] ? 2'd2 : 2'd0;
        if (o >= 0) begin
            g[o] = 1'b1;
            st   = 2'd1;
            mr   = req_rd[o] & ~s_resp;
            mw   = req_wr[o] & ~s_resp;
        end
        return {st, 4'(m_last[k]), g, g & {16{s_resp}}, mr, mw};
    endfunction

    function automatic logic [39:0] dut_obs(input int k);
        case (k)
            0:       return {st4, 4'(i4), 16'(g4), 16'(ro4), mr4, mw4};
            1:       return {st3, 4'(i3), 16'(g3), 16'(ro3), mr3, mw3};
            default: return {st2, 4'(i2), 16'(g2), 16'(ro2), mr2, mw2};
        endcase
    endfunction

    // ---------------- driver tasks ----------------
    // Inputs change just after the falling edge; outputs are checked 1 ns later.
    task automatic drive(input logic [15:0] rd, input logic [15:0] wr,
                         input logic resp);
        req_rd = rd;
        req_wr = wr;
        s_resp = resp;
        #1;
    endtask

    task automatic tick();
        if (!rst_n) model_reset();
        for (int k = 0; k < 3; k++) begin
            compare($sformatf("model_u%0d", NR[k]), 64'(dut_obs(k)), 64'(model_obs(k)));
        end
        @(posedge clk);
        if (rst_n) model_step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(16'hFFFF, 16'hFFFF, 1'b1);
        compare("reset_u4", 64'({st4, i4, g4, ro4, mr4, mw4}), 64'd0);
        compare("reset_u2", 64'({st2, i2, g2, ro2, mr2, mw2}), 64'd0);
        tick();
        tick();
        drive(16'h0, 16'h0, 1'b0);
        rst_n = 1'b1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [3:0] rd;
        logic [3:0] wr;
        logic       resp;
        logic [3:0] g;
        logic [3:0] ro;
        logic       mr;
        logic       mw;
        logic [1:0] idx;
    } vec_t;

    vec_t        tbl [25];
    logic [15:0] r_rd, r_wr;

    initial begin
        // round-robin walk with all four requesting, then abort and spurious strobes
        tbl[0]  = '{4'hF, 4'h0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 2'd0};
        tbl[1]  = '{4'hF, 4'h0, 1'b1, 4'h1, 4'h1, 1'b0, 1'b0, 2'd0};
        tbl[2]  = '{4'hF, 4'h0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 2'd0};
        tbl[3]  = '{4'hF, 4'h0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 2'd0};
        tbl[4]  = '{4'hF, 4'h0, 1'b0, 4'h2, 4'h0, 1'b1, 1'b0, 2'd1};
        tbl[5]  = '{4'hF, 4'h0, 1'b1, 4'h2, 4'h2, 1'b0, 1'b0, 2'd1};
        tbl[6]  = '{4'hF, 4'h0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 2'd1};
        tbl[7]  = '{4'hF, 4'h0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 2'd1};
        tbl[8]  = '{4'hF, 4'h0, 1'b1, 4'h4, 4'h4, 1'b0, 1'b0, 2'd2};
        tbl[9]  = '{4'hF, 4'h0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 2'd2};
        tbl[10] = '{4'hF, 4'h0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 2'd2};
        tbl[11] = '{4'hF, 4'h0, 1'b1, 4'h8, 4'h8, 1'b0, 1'b0, 2'd3};
        tbl[12] = '{4'hF, 4'h0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 2'd3};
        tbl[13] = '{4'hF, 4'h0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 2'd3};
        tbl[14] = '{4'hF, 4'h1, 1'b0, 4'h1, 4'h0, 1'b1, 1'b1, 2'd0};
        tbl[15] = '{4'hF, 4'h0, 1'b1, 4'h1, 4'h1, 1'b0, 1'b0, 2'd0};
        tbl[16] = '{4'h6, 4'h0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 2'd0};
        tbl[17] = '{4'h6, 4'h0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 2'd0};
        tbl[18] = '{4'h6, 4'h0, 1'b0, 4'h2, 4'h0, 1'b1, 1'b0, 2'd1};
        tbl[19] = '{4'h4, 4'h0, 1'b0, 4'h2, 4'h0, 1'b0, 1'b0, 2'd1};
        tbl[20] = '{4'h4, 4'h0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 2'd1};
        tbl[21] = '{4'h4, 4'h0, 1'b1, 4'h4, 4'h4, 1'b0, 1'b0, 2'd2};
        tbl[22] = '{4'h0, 4'h0, 1'b1, 4'h0, 4'h0, 1'b0, 1'b0, 2'd2};
        tbl[23] = '{4'h0, 4'h0, 1'b1, 4'h0, 4'h0, 1'b0, 1'b0, 2'd2};
        tbl[24] = '{4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 2'd2};

        rst_n  = 1'b0;
        req_rd = '0;
        req_wr = '0;
        s_resp = 1'b0;
        model_reset();
        @(negedge clk);
        do_reset();

        for (int i = 0; i < 25; i++) begin
            drive(16'(tbl[i].rd), 16'(tbl[i].wr), tbl[i].resp);
            compare($sformatf("tbl_row%0d", i),
                    64'({g4, ro4, mr4, mw4, i4}),
                    64'({tbl[i].g, tbl[i].ro, tbl[i].mr, tbl[i].mw, tbl[i].idx}));
            tick();
        end

        // pointer at 2 with only req0 active (u3), then fixed priority (u2)
        do_reset();
        drive(16'h2, 16'h0, 1'b0); tick();
        drive(16'h2, 16'h0, 1'b1);
        compare("t3_first_g", 64'(g3), 64'(3'b010));
        tick();
        drive(16'h1, 16'h0, 1'b0); tick();
        drive(16'h1, 16'h0, 1'b0); tick();
        drive(16'h1, 16'h0, 1'b1);
        compare("t3_wrap_g", 64'({g3, ro3}), 64'({3'b001, 3'b001}));
        tick();
        drive(16'h3, 16'h0, 1'b0); tick();
        drive(16'h3, 16'h0, 1'b0); tick();
        drive(16'h3, 16'h0, 1'b0);
        compare("t3_ptr1_g", 64'(g3), 64'(3'b010));
        compare("t1_fixed_g", 64'(g2), 64'(2'b01));
        tick();
        drive(16'h3, 16'h0, 1'b1);
        compare("t1_resp", 64'(ro2), 64'(2'b01));
        tick();
        drive(16'h3, 16'h0, 1'b0);
        compare("t1_gap_g", 64'(g2), 64'(2'b00));
        tick();
        drive(16'h3, 16'h0, 1'b0); tick();
        drive(16'h3, 16'h0, 1'b0);
        compare("t1_regrant", 64'(g2), 64'(2'b01));
        tick();
        drive(16'h2, 16'h0, 1'b1); tick();
        drive(16'h2, 16'h0, 1'b0); tick();
        drive(16'h2, 16'h0, 1'b0); tick();
        drive(16'h2, 16'h0, 1'b0);
        compare("t1_req1_g", 64'(g2), 64'(2'b10));
        tick();

        // asynchronous reset in the middle of an access with s_resp high
        do_reset();
        drive(16'h4, 16'h0, 1'b0); tick();
        drive(16'h4, 16'h0, 1'b1); tick();
        drive(16'h4, 16'h0, 1'b0); tick();
        drive(16'h4, 16'h0, 1'b0); tick();
        drive(16'h4, 16'h0, 1'b0);
        compare("t5_busy_g", 64'(g4), 64'(4'b0100));
        rst_n = 1'b0;
        drive(16'h4, 16'h0, 1'b1);
        compare("t5_async", 64'({st4, g4, ro4, mr4, mw4}), 64'd0);
        tick();
        drive(16'hF, 16'h0, 1'b0);
        rst_n = 1'b1;
        tick();
        drive(16'hF, 16'h0, 1'b0);
        compare("t5_from0_g", 64'(g4), 64'(4'b0001));
        tick();

        // randomized traffic against the model
        r_rd = '0;
        r_wr = '0;
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 3) == 0) begin
                r_rd = 16'($urandom);
                r_wr = 16'($urandom & $urandom);
            end
            rst_n = ($urandom_range(0, 299) != 0);
            drive(r_rd, r_wr, ($urandom_range(0, 3) == 0));
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
